// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : cache_ctrl_pkg
//  Purpose   : Shared FSM state encoding and one-hot helper for the N-way
//              set-associative cache controller.
//  Revision  : 1.0  initial release
// ============================================================================
package cache_ctrl_pkg;

  localparam int MAX_WAYS = 8;
  localparam int MAX_WW   = $clog2(MAX_WAYS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WB      = 3'd2,
    S_STALL   = 3'd3,
    S_FILL    = 3'd4
  } state_t;

  // One-hot decode of a way index, sized for the widest supported cache.
  function automatic logic [MAX_WAYS-1:0] onehot(input logic [MAX_WW-1:0] idx);
    logic [MAX_WAYS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nway_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface : nway_cache_ctrl_if
//  Purpose   : Processor request, per-way array status, memory handshake and
//              array/memory control strobes of the cache controller.
//  Revision  : 1.0  initial release
// ============================================================================
interface nway_cache_ctrl_if #(
  parameter int NUM_WAYS = 4,
  parameter int WORDS    = 4
);
  localparam int OW = $clog2(WORDS);

  logic                req_rd;
  logic                req_wr;
  logic [NUM_WAYS-1:0] hit;
  logic [NUM_WAYS-1:0] valid;
  logic [NUM_WAYS-1:0] dirty;
  logic                mem_stall;

  logic                cache_rdy;
  logic                done;
  logic                cache_hit;
  logic                err;
  logic [NUM_WAYS-1:0] way_en;
  logic                comp;
  logic                write;
  logic                valid_in;
  logic                sel_data_cache;
  logic                soff;
  logic                soff_mem;
  logic                stag;
  logic                mem_rd;
  logic                mem_wr;
  logic [OW-1:0]       offset_cache;
  logic [OW-1:0]       offset_mem;

  // Requester / array / memory side
  modport master (
    output req_rd, req_wr, hit, valid, dirty, mem_stall,
    input  cache_rdy, done, cache_hit, err, way_en, comp, write, valid_in,
           sel_data_cache, soff, soff_mem, stag, mem_rd, mem_wr,
           offset_cache, offset_mem
  );

  // Controller side
  modport slave (
    input  req_rd, req_wr, hit, valid, dirty, mem_stall,
    output cache_rdy, done, cache_hit, err, way_en, comp, write, valid_in,
           sel_data_cache, soff, soff_mem, stag, mem_rd, mem_wr,
           offset_cache, offset_mem
  );
endinterface
`default_nettype wire

// File: rtl/nway_cache_ctrl_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module    : nway_victim_sel
//  Purpose   : Victim way selection: lowest-index invalid way, otherwise the
//              round-robin pointer, which advances only when it was used.
//  Revision  : 1.0  initial release
// ============================================================================
module nway_victim_sel #(
  parameter int NUM_WAYS = 4,
  localparam int WW      = $clog2(NUM_WAYS)
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [NUM_WAYS-1:0] i_valid,
  input  wire logic                i_advance,
  output      logic [WW-1:0]       o_victim
);

  logic [WW-1:0] r_rr_ptr;
  logic [WW-1:0] w_first_inv;
  logic          w_found;

  // Priority encoder over ~valid; descending scan so the lowest index wins
  always_comb begin
    w_first_inv = '0;
    w_found     = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        w_first_inv = WW'(i);
        w_found     = 1'b1;
      end
    end
  end

  assign o_victim = w_found ? w_first_inv : r_rr_ptr;

  // Round-robin pointer; wraps naturally since NUM_WAYS is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (i_advance && !w_found) begin
      r_rr_ptr <= r_rr_ptr + WW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nway_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : nway_cache_ctrl
//  Purpose   : Control FSM for an N-way set-associative, write-back,
//              write-allocate cache: hit decode, write-back and refill bursts.
//  Revision  : 1.0  initial release
// ============================================================================
module nway_cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WORDS    = 4,
  parameter int MEM_LAT  = 2
) (
  input wire logic          clk,
  input wire logic          rst,
  nway_cache_ctrl_if.slave  bus
);

  localparam int OW = $clog2(WORDS);
  localparam int CW = OW + 3;
  localparam int WW = $clog2(NUM_WAYS);

  localparam logic [CW-1:0] c_WB_LAST   = CW'(WORDS - 1);
  localparam logic [CW-1:0] c_FILL_LAST = CW'(WORDS + MEM_LAT - 1);
  localparam logic [CW-1:0] c_WORDS     = CW'(WORDS);
  localparam logic [CW-1:0] c_LAT       = CW'(MEM_LAT);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_op_wr;
  logic          r_miss_q;
  logic          r_both_q;
  logic [WW-1:0] r_victim_q;

  logic [NUM_WAYS-1:0] w_hv;
  logic                w_any_hv;
  logic                w_multi_hv;
  logic                w_req;
  logic                w_advance;
  logic [WW-1:0]       w_victim;
  logic                w_victim_dirty;
  logic [NUM_WAYS-1:0] w_victim_oh;
  logic [OW-1:0]       w_cnt_off;
  logic [OW-1:0]       w_fill_off;

  assign w_hv           = bus.hit & bus.valid;
  assign w_any_hv       = |w_hv;
  assign w_multi_hv     = (w_hv & (w_hv - NUM_WAYS'(1))) != '0;
  assign w_req          = bus.req_rd | bus.req_wr;
  assign w_advance      = (r_state == S_COMPARE) && !w_any_hv;
  assign w_victim_dirty = bus.dirty[w_victim] & bus.valid[w_victim];
  assign w_victim_oh    = NUM_WAYS'(onehot(MAX_WW'(r_victim_q)));
  assign w_cnt_off      = OW'(r_cnt);
  assign w_fill_off     = OW'(r_cnt - c_LAT);

  nway_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (bus.valid),
    .i_advance (w_advance),
    .o_victim  (w_victim)
  );

  // Main sequencer: state, burst counter and per-access context
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op_wr    <= 1'b0;
      r_miss_q   <= 1'b0;
      r_both_q   <= 1'b0;
      r_victim_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_op_wr  <= bus.req_wr;
            r_miss_q <= 1'b0;
            r_both_q <= bus.req_rd & bus.req_wr;
            r_state  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_cnt    <= '0;
          // rd+wr conflict is reported once, on the first compare only
          r_both_q <= 1'b0;
          if (w_any_hv) begin
            r_state <= S_IDLE;
          end else begin
            r_victim_q <= w_victim;
            r_miss_q   <= 1'b1;
            r_state    <= w_victim_dirty ? S_WB : S_STALL;
          end
        end
        S_WB: begin
          if (r_cnt == c_WB_LAST) begin
            r_cnt   <= '0;
            r_state <= S_STALL;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STALL: begin
          r_cnt <= '0;
          if (!bus.mem_stall) begin
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          // a started refill burst is never held off by mem_stall
          if (r_cnt == c_FILL_LAST) begin
            r_cnt   <= '0;
            r_state <= S_COMPARE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from state, burst count and the latched victim
  always_comb begin
    bus.cache_rdy      = 1'b0;
    bus.done           = 1'b0;
    bus.cache_hit      = 1'b0;
    bus.err            = 1'b0;
    bus.way_en         = '0;
    bus.comp           = 1'b0;
    bus.write          = 1'b0;
    bus.valid_in       = 1'b0;
    bus.sel_data_cache = 1'b0;
    bus.soff           = 1'b0;
    bus.soff_mem       = 1'b0;
    bus.stag           = 1'b0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.offset_cache   = '0;
    bus.offset_mem     = '0;
    case (r_state)
      S_IDLE: begin
        bus.cache_rdy = !w_req;
      end
      S_COMPARE: begin
        bus.comp      = 1'b1;
        bus.way_en    = '1;
        bus.write     = r_op_wr;
        bus.valid_in  = r_op_wr;
        bus.done      = w_any_hv;
        bus.cache_hit = w_any_hv & !r_miss_q;
        bus.err       = w_multi_hv | r_both_q;
      end
      S_WB: begin
        bus.mem_wr       = 1'b1;
        bus.stag         = 1'b1;
        bus.soff         = 1'b1;
        bus.soff_mem     = 1'b1;
        bus.way_en       = w_victim_oh;
        bus.offset_cache = w_cnt_off;
        bus.offset_mem   = w_cnt_off;
      end
      S_FILL: begin
        if (r_cnt < c_WORDS) begin
          bus.mem_rd     = 1'b1;
          bus.soff_mem   = 1'b1;
          bus.offset_mem = w_cnt_off;
        end
        if (r_cnt >= c_LAT) begin
          bus.write          = 1'b1;
          bus.valid_in       = 1'b1;
          bus.sel_data_cache = 1'b1;
          bus.soff           = 1'b1;
          bus.way_en         = w_victim_oh;
          bus.offset_cache   = w_fill_off;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nway_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : tb_nway_cache_ctrl
//  Purpose   : Self-checking bench for nway_cache_ctrl. Each access is
//              expanded by a transaction-level model into a per-cycle table
//              of inputs and expected outputs, which is then played back.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_nway_cache_ctrl;

  localparam int N = 4;
  localparam int W = 4;
  localparam int L = 2;

  typedef struct packed {
    logic       rdy, done, chit, err;
    logic [3:0] way_en;
    logic       comp, write, vin, sel, soff, soffm, stag, mrd, mwr;
    logic [1:0] oc, om;
  } out_t;

  typedef struct {
    logic       rst, rd, wr, stall, chk;
    logic [3:0] hit, valid, dirty;
    out_t       exp;
    string      tag;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nway_cache_ctrl_if #(.NUM_WAYS(N), .WORDS(W)) bus ();

  nway_cache_ctrl #(.NUM_WAYS(N), .WORDS(W), .MEM_LAT(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  out_t w_act;
  assign w_act = {bus.cache_rdy, bus.done, bus.cache_hit, bus.err, bus.way_en,
                  bus.comp, bus.write, bus.valid_in, bus.sel_data_cache, bus.soff,
                  bus.soff_mem, bus.stag, bus.mem_rd, bus.mem_wr,
                  bus.offset_cache, bus.offset_mem};

  cyc_t sched[$];
  cyc_t cur;
  bit   have_cur = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   model_rr = 0;

  // A non-IDLE cycle: inputs the DUT must ignore are randomised
  function automatic cyc_t busy(input string tag);
    cyc_t c;
    c.rst   = 1'b0;
    c.rd    = 1'($urandom);
    c.wr    = 1'($urandom);
    c.stall = 1'($urandom);
    c.hit   = 4'($urandom);
    c.valid = 4'($urandom);
    c.dirty = 4'($urandom);
    c.chk   = 1'b1;
    c.exp   = '0;
    c.tag   = tag;
    return c;
  endfunction

  task automatic idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = busy("idle");
      c.rd = 1'b0;
      c.wr = 1'b0;
      c.exp.rdy = 1'b1;
      sched.push_back(c);
    end
  endtask

  // Expand one access into cycles. lat = cycles from request to done.
  task automatic tx(input bit rd, input bit wr, input logic [3:0] hit,
                    input logic [3:0] valid, input logic [3:0] dirty,
                    input int stalls, input int rst_at,
                    output int victim, output int lat);
    cyc_t c;
    int   start;
    bit   op_wr;
    logic [3:0] hv;
    start  = sched.size();
    op_wr  = wr;
    hv     = hit & valid;
    victim = -1;
    lat    = -1;

    c = busy("req");
    c.rd = rd;
    c.wr = wr;
    sched.push_back(c);

    c = busy(hv != 0 ? "cmp_hit" : "cmp_miss");
    c.hit = hit; c.valid = valid; c.dirty = dirty;
    c.exp.comp = 1'b1; c.exp.way_en = 4'hF;
    c.exp.write = op_wr; c.exp.vin = op_wr;
    c.exp.err = (rd && wr) || ($countones(hv) > 1);
    if (hv != 0) begin
      c.exp.done = 1'b1;
      c.exp.chit = 1'b1;
      sched.push_back(c);
      lat = sched.size() - 1 - start;
      return;
    end
    sched.push_back(c);

    for (int i = 0; i < N; i++)
      if (!valid[i] && victim < 0) victim = i;
    if (victim < 0) begin
      victim   = model_rr;
      model_rr = (model_rr + 1) % N;
    end

    if (dirty[victim] && valid[victim]) begin
      for (int i = 0; i < W; i++) begin
        c = busy("wb");
        c.exp.mwr = 1'b1; c.exp.stag = 1'b1; c.exp.soff = 1'b1; c.exp.soffm = 1'b1;
        c.exp.way_en = 4'(1 << victim);
        c.exp.oc = 2'(i); c.exp.om = 2'(i);
        sched.push_back(c);
      end
    end

    for (int s = 0; s < stalls; s++) begin
      c = busy("stall");
      c.stall = 1'b1;
      sched.push_back(c);
    end
    c = busy("stall_end");
    c.stall = 1'b0;
    sched.push_back(c);

    for (int i = 0; i < W + L; i++) begin
      c = busy("fill");
      if (i < W) begin
        c.exp.mrd = 1'b1; c.exp.soffm = 1'b1; c.exp.om = 2'(i);
      end
      if (i >= L) begin
        c.exp.write = 1'b1; c.exp.vin = 1'b1; c.exp.sel = 1'b1; c.exp.soff = 1'b1;
        c.exp.way_en = 4'(1 << victim);
        c.exp.oc = 2'(i - L);
      end
      if (i == rst_at) begin
        c.rst    = 1'b1;
        sched.push_back(c);
        model_rr = 0;
        return;
      end
      sched.push_back(c);
    end

    c = busy("recmp");
    c.hit   = 4'(1 << victim);
    c.valid = valid | 4'(1 << victim);
    c.exp.comp = 1'b1; c.exp.way_en = 4'hF;
    c.exp.write = op_wr; c.exp.vin = op_wr;
    c.exp.done = 1'b1;
    sched.push_back(c);
    lat = sched.size() - 1 - start;
  endtask

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Compare DUT outputs against the table entry of the current cycle
  always @(negedge clk) begin
    if (have_cur && cur.chk) begin
      checks++;
      if (w_act !== cur.exp) begin
        errors++;
        $display("FAIL %s @%0t: got %h expected %h", cur.tag, $time, w_act, cur.exp);
      end
    end
  end

  initial begin
    cyc_t c;
    int   v, lat, op, hit, valid;

    // reset for two cycles, then the idle state must show cache_rdy
    for (int i = 0; i < 2; i++) begin
      c = busy("reset");
      c.rst = 1'b1; c.rd = 1'b0; c.wr = 1'b0; c.chk = 1'b0;
      sched.push_back(c);
    end
    idle(2);

    // read hit in way 2
    tx(1, 0, 4'b0100, 4'b0100, 4'b0000, 0, -1, v, lat);
    lit("hit_latency", lat, 1);
    idle(1);
    // clean read miss, way 3 invalid
    tx(1, 0, 4'b0000, 4'b0111, 4'b0000, 0, -1, v, lat);
    lit("clean_miss_victim", v, 3);
    lit("clean_miss_latency", lat, 9);
    // dirty write miss, all valid: round-robin victim 0
    tx(0, 1, 4'b0000, 4'b1111, 4'b1111, 0, -1, v, lat);
    lit("dirty_miss_victim", v, 0);
    lit("dirty_miss_latency", lat, 13);
    lit("rr_after_dirty", model_rr, 1);
    // dirty miss with 5 stall cycles after write-back
    tx(1, 0, 4'b0000, 4'b1111, 4'b0010, 5, -1, v, lat);
    lit("stall_miss_victim", v, 1);
    lit("stall_miss_latency", lat, 18);
    // multi-hit, then rd+wr together
    tx(1, 0, 4'b1001, 4'b1001, 4'b0000, 0, -1, v, lat);
    tx(1, 1, 4'b0010, 4'b0010, 4'b0000, 0, -1, v, lat);
    // reset on FILL cycle 1, then rr_ptr must be back at 0
    tx(1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 1, v, lat);
    lit("rst_fill_victim", v, 2);
    idle(1);
    tx(1, 0, 4'b0000, 4'b1111, 4'b0000, 0, -1, v, lat);
    lit("victim_after_rst", v, 0);

    // randomized accesses
    for (int t = 0; t < 40; t++) begin
      idle($urandom_range(0, 2));
      op    = $urandom_range(0, 5);
      hit   = $urandom_range(0, 15);
      valid = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) hit = 0;
      if ($urandom_range(0, 2) == 0) valid = 15;
      tx(op <= 2 || op == 5, op >= 3, 4'(hit), 4'(valid), 4'($urandom),
         $urandom_range(0, 3), -1, v, lat);
    end
    idle(2);

    // playback
    foreach (sched[k]) begin
      @(posedge clk);
      #1;
      rst           = sched[k].rst;
      bus.req_rd    = sched[k].rd;
      bus.req_wr    = sched[k].wr;
      bus.hit       = sched[k].hit;
      bus.valid     = sched[k].valid;
      bus.dirty     = sched[k].dirty;
      bus.mem_stall = sched[k].stall;
      cur           = sched[k];
      have_cur      = 1'b1;
    end
    @(posedge clk);
    #1;
    have_cur = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
